// File: rtl/alu_iter_exec.sv
// alu_iter_exec: execute-stage ALU with 1-cycle ops
// and bit-serial shifts behind a start/done handshake.
module alu_iter_exec #(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = 5
) (
  input  logic              i_Clk,
  input  logic              i_Rst_n,
  input  logic              i_Start,
  input  logic [3:0]        i_ALUControlLines,
  input  logic [XLEN-1:0]   i_A,
  input  logic [XLEN-1:0]   i_B,
  output logic              o_Ready,
  output logic              o_Done,
  output logic [XLEN-1:0]   o_Result,
  output logic              o_Zero,
  output logic              o_Illegal
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b1000;
  localparam logic [3:0] OP_SLL  = 4'b0001;
  localparam logic [3:0] OP_SLT  = 4'b0010;
  localparam logic [3:0] OP_SLTU = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SRA  = 4'b1101;
  localparam logic [3:0] OP_OR   = 4'b0110;
  localparam logic [3:0] OP_AND  = 4'b0111;

  state_t              state;
  logic [XLEN-1:0]     acc;
  logic [SHAMT_W-1:0]  cnt;
  logic                sh_left;
  logic                sh_arith;

  logic [XLEN-1:0]     res_c;
  logic                ill_c;
  logic                shift_c;
  logic [XLEN-1:0]     acc_next;
  logic [SHAMT_W-1:0]  shamt;
  logic                accept;

  assign shamt   = i_B[SHAMT_W-1:0];
  assign accept  = i_Start && (state != SHIFT);
  assign o_Ready = (state != SHIFT);
  assign o_Done  = (state == DONE);

  // Single-cycle result; a shift here only matters when shamt is 0.
  always_comb begin
    res_c   = '0;
    ill_c   = 1'b0;
    shift_c = 1'b0;
    unique case (i_ALUControlLines)
      OP_ADD:  res_c = i_A + i_B;
      OP_SUB:  res_c = i_A - i_B;
      OP_SLT:  res_c = {{(XLEN-1){1'b0}},
                        ($signed(i_A) < $signed(i_B))};
      OP_SLTU: res_c = {{(XLEN-1){1'b0}}, (i_A < i_B)};
      OP_XOR:  res_c = i_A ^ i_B;
      OP_OR:   res_c = i_A | i_B;
      OP_AND:  res_c = i_A & i_B;
      OP_SLL, OP_SRL, OP_SRA: begin
        res_c   = i_A;
        shift_c = 1'b1;
      end
      default: ill_c = 1'b1;
    endcase
  end

  // One-bit step of the serial shifter.
  always_comb begin
    acc_next = acc;
    if (sh_left)
      acc_next = {acc[XLEN-2:0], 1'b0};
    else
      acc_next = {sh_arith & acc[XLEN-1], acc[XLEN-1:1]};
  end

  // Control FSM, shift datapath and registered results.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      sh_left   <= 1'b0;
      sh_arith  <= 1'b0;
      o_Result  <= '0;
      o_Zero    <= 1'b1;
      o_Illegal <= 1'b0;
    end else if (accept) begin
      if (shift_c && (shamt != '0)) begin
        acc      <= i_A;
        cnt      <= shamt;
        sh_left  <= (i_ALUControlLines == OP_SLL);
        sh_arith <= i_ALUControlLines[3];
        state    <= SHIFT;
      end else begin
        o_Result  <= res_c;
        o_Zero    <= (res_c == '0);
        o_Illegal <= ill_c;
        state     <= DONE;
      end
    end else begin
      unique case (state)
        SHIFT: begin
          acc <= acc_next;
          cnt <= cnt - 1'b1;
          if (cnt == SHAMT_W'(1)) begin
            o_Result  <= acc_next;
            o_Zero    <= (acc_next == '0);
            o_Illegal <= 1'b0;
            state     <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_iter_exec.sv
// tb_alu_iter_exec: directed self-checking bench
// for the iterative execute unit.
module tb_alu_iter_exec;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [3:0]  ctl;
  logic [31:0] a;
  logic [31:0] b;
  logic        ready;
  logic        done;
  logic [31:0] result;
  logic        zero;
  logic        illegal;

  int n_cmp;
  int n_bad;

  alu_iter_exec #(.XLEN(32), .SHAMT_W(5)) dut (
    .i_Clk            (clk),
    .i_Rst_n          (rst_n),
    .i_Start          (start),
    .i_ALUControlLines(ctl),
    .i_A              (a),
    .i_B              (b),
    .o_Ready          (ready),
    .o_Done           (done),
    .o_Result         (result),
    .o_Zero           (zero),
    .o_Illegal        (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one request at a negedge; return 1ns after the accept edge.
  task automatic launch(input logic [3:0] c,
                        input logic [31:0] va,
                        input logic [31:0] vb);
    @(negedge clk);
    ctl   = c;
    a     = va;
    b     = vb;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    start = 1'b0;
    ctl   = 4'b0000;
    a     = '0;
    b     = '0;
    #12;
    n_cmp++;
    if ({ready, done, zero, illegal} !== 4'b1010 || result !== 32'h0) begin
      n_bad++;
      $display("FAIL reset: rdy/done/zero/ill=%b res=%h want 1010 0",
               {ready, done, zero, illegal}, result);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_add;
    n_cmp++;
    if (ready !== 1'b1) begin
      n_bad++;
      $display("FAIL add_ready_pre: got %b want 1", ready);
    end
    launch(4'b0000, 32'h7FFF_FFFF, 32'h1);
    n_cmp++;
    if (done !== 1'b1 || result !== 32'h8000_0000 ||
        zero !== 1'b0 || ready !== 1'b1) begin
      n_bad++;
      $display("FAIL add: done=%b res=%h zero=%b rdy=%b want 1 80000000 0 1",
               done, result, zero, ready);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (done !== 1'b0 || result !== 32'h8000_0000) begin
      n_bad++;
      $display("FAIL add_hold: done=%b res=%h want 0 80000000",
               done, result);
    end
  endtask

  task automatic test_compare;
    launch(4'b1000, 32'h1234_5678, 32'h1234_5678);
    n_cmp++;
    if (done !== 1'b1 || result !== 32'h0 || zero !== 1'b1) begin
      n_bad++;
      $display("FAIL sub: done=%b res=%h zero=%b want 1 0 1",
               done, result, zero);
    end
    launch(4'b0010, 32'hFFFF_FFFF, 32'h1);
    n_cmp++;
    if (done !== 1'b1 || result !== 32'h1 || zero !== 1'b0) begin
      n_bad++;
      $display("FAIL slt: done=%b res=%h zero=%b want 1 1 0",
               done, result, zero);
    end
    launch(4'b0011, 32'hFFFF_FFFF, 32'h1);
    n_cmp++;
    if (done !== 1'b1 || result !== 32'h0 || zero !== 1'b1) begin
      n_bad++;
      $display("FAIL sltu: done=%b res=%h zero=%b want 1 0 1",
               done, result, zero);
    end
    launch(4'b0100, 32'hFF00_FF00, 32'h0FF0_0FF0);
    n_cmp++;
    if (result !== 32'hF0F0_F0F0) begin
      n_bad++;
      $display("FAIL xor: res=%h want f0f0f0f0", result);
    end
  endtask

  task automatic test_shift;
    int n;
    int low;
    int moved;
    // SRA by 31; result before it is the XOR value.
    launch(4'b1101, 32'h8000_0000, 32'd31);
    n = 0; low = 0; moved = 0;
    while (done !== 1'b1 && n < 100) begin
      if (ready === 1'b0) low++;
      if (result !== 32'hF0F0_F0F0) moved++;
      @(posedge clk);
      #1;
      n++;
    end
    n_cmp++;
    if (n != 31 || low != 31 || moved != 0) begin
      n_bad++;
      $display("FAIL sra_timing: edges=%0d low=%0d moved=%0d want 31 31 0",
               n, low, moved);
    end
    n_cmp++;
    if (result !== 32'hFFFF_FFFF || zero !== 1'b0 || ready !== 1'b1) begin
      n_bad++;
      $display("FAIL sra: res=%h zero=%b rdy=%b want ffffffff 0 1",
               result, zero, ready);
    end
    launch(4'b0101, 32'h8000_0000, 32'd31);
    n = 0;
    while (done !== 1'b1 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    n_cmp++;
    if (n != 31 || result !== 32'h1) begin
      n_bad++;
      $display("FAIL srl: edges=%0d res=%h want 31 00000001", n, result);
    end
    launch(4'b0001, 32'h1234_ABCD, 32'h20);
    n_cmp++;
    if (done !== 1'b1 || result !== 32'h1234_ABCD) begin
      n_bad++;
      $display("FAIL sll_zero: done=%b res=%h want 1 1234abcd",
               done, result);
    end
  endtask

  task automatic test_back_to_back;
    int pulses;
    @(negedge clk);
    ctl = 4'b0111; a = 32'hF0F0; b = 32'hFF00; start = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++;
    if (done !== 1'b1 || result !== 32'hF000) begin
      n_bad++;
      $display("FAIL b2b_and: done=%b res=%h want 1 0000f000", done, result);
    end
    @(negedge clk);
    ctl = 4'b0110; a = 32'h1; b = 32'h2;
    @(posedge clk);
    #1;
    start = 1'b0;
    n_cmp++;
    if (done !== 1'b1 || result !== 32'h3) begin
      n_bad++;
      $display("FAIL b2b_or: done=%b res=%h want 1 00000003", done, result);
    end
    // SLL by 4 with a stray request during the shift.
    launch(4'b0001, 32'h1, 32'd4);
    pulses = 0;
    @(negedge clk);
    ctl = 4'b0000; a = 32'h99; b = 32'h1; start = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (i == 1) start = 1'b0;
      if (done === 1'b1) pulses++;
    end
    n_cmp++;
    if (pulses != 1 || result !== 32'h10) begin
      n_bad++;
      $display("FAIL sll_ignore: pulses=%0d res=%h want 1 00000010",
               pulses, result);
    end
  endtask

  task automatic test_illegal;
    launch(4'b1111, 32'h5, 32'h6);
    n_cmp++;
    if (done !== 1'b1 || result !== 32'h0 ||
        illegal !== 1'b1 || zero !== 1'b1) begin
      n_bad++;
      $display("FAIL illegal: done=%b res=%h ill=%b zero=%b want 1 0 1 1",
               done, result, illegal, zero);
    end
    launch(4'b0000, 32'h2, 32'h3);
    n_cmp++;
    if (done !== 1'b1 || result !== 32'h5 || illegal !== 1'b0) begin
      n_bad++;
      $display("FAIL illegal_clear: done=%b res=%h ill=%b want 1 5 0",
               done, result, illegal);
    end
  endtask

  task automatic test_reset_mid_shift;
    int pulses;
    launch(4'b0001, 32'h1, 32'd20);
    for (int i = 0; i < 6; i++) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (ready !== 1'b1 || result !== 32'h0 ||
        zero !== 1'b1 || done !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_mid: rdy=%b res=%h zero=%b done=%b want 1 0 1 0",
               ready, result, zero, done);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) pulses++;
    end
    n_cmp++;
    if (pulses != 0) begin
      n_bad++;
      $display("FAIL rst_no_done: pulses=%0d want 0", pulses);
    end
    launch(4'b0000, 32'h7, 32'h8);
    n_cmp++;
    if (done !== 1'b1 || result !== 32'hF) begin
      n_bad++;
      $display("FAIL rst_recover: done=%b res=%h want 1 0000000f",
               done, result);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_add();
    test_compare();
    test_shift();
    test_back_to_back();
    test_illegal();
    test_reset_mid_shift();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
